uart_tx_arbiter: RTL

Round-robin packet arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters. Each requester offers bytes on a valid/ready handshake with a last flag. Once granted, a requester keeps the transmitter until its last byte has left the line, so messages never interleave. The block sits between the client logic and the UART TX core, driving the core's write strobe and data byte and observing its busy flag.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/uart_rr_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for the UART TX packet arbiter
//
// Purpose : FSM state encoding, requester limit and index-width helper used by
//           uart_tx_arbiter and uart_rr_pick.
// Ports   : none (package).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int MAX_REQ = 8;

  // Width of a requester index; never narrower than one bit and never wider
  // than what the largest supported requester count needs.
  function automatic int REQ_IDX_W(input int n);
    int m;
    m = (n > MAX_REQ) ? MAX_REQ : n;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
//
// Purpose : selects the first set request bit strictly after the pointer,
//           wrapping around, so the last winner has the lowest priority.
// Ports   : req_i  [NUM_REQ]  request vector
//           ptr_i  [IDX_W]    index of the previous winner
//           gnt_o  [NUM_REQ]  one-hot winner (zero when no request)
//           idx_o  [IDX_W]    index of the winner
//           any_o             at least one request is set
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    // Offsets 1..NUM_REQ: the pointer itself is checked last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter in front of one UART TX core
//
// Purpose : shares a UART transmitter between NUM_REQ byte streams; a granted
//           requester keeps the line until its last byte has been sent.
// Config  : UART_ARB_TIMEOUT_EN - release a lock after TIMEOUT_CYCLES idle
//           cycles in SEND.
// Ports   : i_clk, i_rstn         clock, synchronous active-low reset
//           i_req_valid [N]       per-requester byte valid
//           i_req_data  [8N]      per-requester byte, requester k at [8k+7:8k]
//           i_req_last  [N]       final byte of the packet
//           o_req_ready [N]       byte accepted this cycle (owner only)
//           o_tx_wr               one-cycle write strobe to the TX core
//           o_tx_data   [8]       byte to the TX core
//           i_tx_busy             TX core busy
//           o_grant     [N]       one-hot lock owner, zero when idle
//           o_active              a lock is held
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_wr,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_active
);

  localparam int IDX_W = REQ_IDX_W(NUM_REQ);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               last_q;
  logic               tx_wr_q;
  logic [7:0]         tx_data_q;
  logic               active_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               owner_valid;
  logic               owner_last;
  logic [7:0]         owner_data;
  logic               handshake;
  logic               to_expire;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign owner_valid = i_req_valid[idx_q];
  assign owner_last  = i_req_last[idx_q];
  assign owner_data  = i_req_data[{idx_q, 3'b000} +: 8];

  // A busy core (possibly driven by someone else) blocks the handshake.
  assign handshake   = (state_q == SEND) && owner_valid && !i_tx_busy;
  assign o_req_ready = handshake ? grant_q : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_idle;

  assign to_idle   = (state_q == SEND) && !owner_valid;
  assign to_expire = to_idle && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive owner-idle cycles in SEND; any other cycle restarts it.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      to_cnt_q <= '0;
    end else if (to_idle && !to_expire) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;

  assign to_expire      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      last_q    <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      active_q  <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_gnt;
            idx_q    <= pick_idx;
            active_q <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= owner_data;
            last_q    <= owner_last;
            state_q   <= WAIT_ACK;
          end else if (to_expire) begin
            ptr_q    <= idx_q;
            grant_q  <= '0;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WAIT_ACK: begin
          // The core raises busy the cycle after the strobe.
          if (i_tx_busy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (last_q) begin
              ptr_q    <= idx_q;
              grant_q  <= '0;
              active_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_wr   = tx_wr_q;
  assign o_tx_data = tx_data_q;
  assign o_grant   = grant_q;
  assign o_active  = active_q;

endmodule
